dmem_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single-port DataMemory (synchronous read, 1-cycle read latency, write on posedge).
- Port 0 is the CPU load/store path; port 1 is the loader/DMA path.
- Serialises accesses, generates one-cycle memRead/memWrite strobes, and returns read data with a valid pulse to the owning requester.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port,
// synchronous-read DataMemory. Writes take 2 cycles per access, reads take 3.
module dmem_arbiter #(
  parameter int WORD     = 16,
  parameter int ADDRESSL = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                we0,
  input  logic [ADDRESSL-1:0] addr0,
  input  logic [WORD-1:0]     wdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [ADDRESSL-1:0] addr1,
  input  logic [WORD-1:0]     wdata1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [WORD-1:0]     rdata0,
  output logic [WORD-1:0]     rdata1,
  output logic [ADDRESSL-1:0] mem_address,
  output logic [WORD-1:0]     mem_write_data,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [WORD-1:0]     mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                op_we_q, op_we_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [WORD-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDRESSL-1:0] mem_address_q, mem_address_d;
  logic [WORD-1:0]     mem_write_data_q, mem_write_data_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;

  logic                any_req;
  logic                pick;
  logic                pick_we;

  // Under contention the port that did not win last time takes the grant.
  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 & req1) ? ~last_grant_q : req1;
    pick_we = pick ? we1 : we0;
  end

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    owner_d          = owner_q;
    op_we_d          = op_we_q;
    rdata0_d         = rdata0_q;
    rdata1_d         = rdata1_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    gnt0_d           = 1'b0;
    gnt1_d           = 1'b0;
    rvalid0_d        = 1'b0;
    rvalid1_d        = 1'b0;
    mem_write_d      = 1'b0;
    mem_read_d       = 1'b0;

    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (any_req) begin
          owner_d          = pick;
          last_grant_d     = pick;
          op_we_d          = pick_we;
          mem_address_d    = pick ? addr1 : addr0;
          mem_write_data_d = pick ? wdata1 : wdata0;
          gnt0_d           = ~pick;
          gnt1_d           = pick;
          mem_write_d      = pick_we;
          mem_read_d       = ~pick_we;
          state_d          = ISSUE;
        end
      end
      ISSUE: state_d = op_we_q ? IDLE : WAIT;
      WAIT: begin
        // Memory output is valid this cycle, one cycle after the read strobe.
        if (owner_q) begin
          rdata1_d  = mem_read_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_read_data;
          rvalid0_d = 1'b1;
        end
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      owner_q          <= 1'b0;
      op_we_q          <= 1'b0;
      gnt0_q           <= 1'b0;
      gnt1_q           <= 1'b0;
      rvalid0_q        <= 1'b0;
      rvalid1_q        <= 1'b0;
      rdata0_q         <= '0;
      rdata1_q         <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      owner_q          <= owner_d;
      op_we_q          <= op_we_d;
      gnt0_q           <= gnt0_d;
      gnt1_q           <= gnt1_d;
      rvalid0_q        <= rvalid0_d;
      rvalid1_q        <= rvalid1_d;
      rdata0_q         <= rdata0_d;
      rdata1_q         <= rdata1_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q      <= mem_write_d;
      mem_read_q       <= mem_read_d;
    end
  end

  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign rvalid0        = rvalid0_q;
  assign rvalid1        = rvalid1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural synchronous-read memory.
module tb_dmem_arbiter;
  localparam int WORD = 16;
  localparam int AW   = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0, we0, req1, we1;
  logic [AW-1:0]   addr0, addr1;
  logic [WORD-1:0] wdata0, wdata1;
  logic            gnt0, gnt1, rvalid0, rvalid1;
  logic [WORD-1:0] rdata0, rdata1;
  logic [AW-1:0]   mem_address;
  logic [WORD-1:0] mem_write_data;
  logic            mem_write, mem_read;
  logic [WORD-1:0] mem_read_data;

  dmem_arbiter #(.WORD(WORD), .ADDRESSL(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory preload: mem[i] = 16'h1000 + i.
  logic            mem_init;
  logic [WORD-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h1000 + 16'(i);
    end else begin
      if (mem_write) mem[mem_address] <= mem_write_data;
      if (mem_read)  mem_read_data    <= mem[mem_address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_rv;
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            delta;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;
  int  last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_rv, input bit port, input bit we,
                      input logic [AW-1:0] a, input logic [15:0] d, input int delta);
    ev_t e;
    e.is_rv = is_rv; e.port = port; e.we = we; e.addr = a; e.data = d; e.delta = delta;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    chk("strobe_exclusive", 32'(mem_read & mem_write), 0);
    chk("gnt_exclusive", 32'(gnt0 & gnt1), 0);
    chk("rvalid_exclusive", 32'(rvalid0 & rvalid1), 0);
    chk("strobe_only_with_gnt", 32'(mem_read | mem_write), 32'(gnt0 | gnt1));
    if (gnt0 | gnt1 | rvalid0 | rvalid1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_event: gnt=%b%b rvalid=%b%b at cycle %0d, expected none",
                 gnt1, gnt0, rvalid1, rvalid0, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.delta >= 0) chk("event_spacing", cyc - last_cyc, e.delta);
        last_cyc = cyc;
        if (!e.is_rv) begin
          chk("gnt_port", {30'd0, gnt1, gnt0}, e.port ? 2 : 1);
          chk("gnt_strobe", {30'd0, mem_write, mem_read}, e.we ? 2 : 1);
          chk("gnt_addr", 32'(mem_address), 32'(e.addr));
          if (e.we) chk("gnt_wdata", 32'(mem_write_data), 32'(e.data));
        end else begin
          chk("rvalid_port", {30'd0, rvalid1, rvalid0}, e.port ? 2 : 1);
          chk("rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.data));
        end
      end
    end
  end

  task automatic drive(input bit port, input bit r, input bit w,
                       input logic [AW-1:0] a, input logic [15:0] d);
    if (port) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else      begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic wait_gnt(input bit port);
    bit seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (port ? gnt1 : gnt0) seen = 1;
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL gnt_timeout: port %0d saw no grant in 30 cycles, expected one", port);
    end
  endtask

  task automatic access(input bit port, input bit we, input logic [AW-1:0] a,
                        input logic [15:0] wd, input logic [15:0] rd_exp);
    push(0, port, we, a, wd, -1);
    if (!we) push(1, port, 0, a, rd_exp, 2);
    drive(port, 1, we, a, wd);
    wait_gnt(port);
    drive(port, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {26'd0, gnt1, gnt0, rvalid1, rvalid0, mem_write, mem_read}, 0);
    chk({tag, "_rdata0"}, 32'(rdata0), 0);
    chk({tag, "_rdata1"}, 32'(rdata1), 0);
    chk({tag, "_mem_address"}, 32'(mem_address), 0);
    chk({tag, "_mem_write_data"}, 32'(mem_write_data), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0;
    check_reset_outputs("reset");

    // Port 0 write then read back.
    access(0, 1, 10'd5, 16'hBEEF, 16'h0000);
    access(0, 0, 10'd5, 16'h0000, 16'hBEEF);
    chk("rdata0_held", 32'(rdata0), 32'h0000BEEF);

    // Fresh reset so last_grant = 1: port 0 wins the first contention.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push(0, 0, 0, 10'd3, 16'h0000, -1);
    push(1, 0, 0, 10'd3, 16'h1003, 2);
    push(0, 1, 0, 10'd7, 16'h0000, 1);
    push(1, 1, 0, 10'd7, 16'h1007, 2);
    drive(0, 1, 0, 10'd3, '0);
    drive(1, 1, 0, 10'd7, '0);
    fork
      begin wait_gnt(0); drive(0, 0, 0, '0, '0); end
      begin wait_gnt(1); drive(1, 0, 0, '0, '0); end
    join
    repeat (3) @(posedge clk);
    #1;

    // Continuous writes from both ports: strict alternation every 2 cycles.
    for (int k = 0; k < 8; k++)
      push(0, k[0], 1, 10'(100 + k), 16'(16'hA100 + k), (k == 0) ? -1 : 2);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          drive(0, 1, 1, 10'(100 + 2 * i), 16'(16'hA100 + 2 * i));
          wait_gnt(0);
        end
        drive(0, 0, 0, '0, '0);
      end
      begin
        for (int j = 0; j < 4; j++) begin
          drive(1, 1, 1, 10'(101 + 2 * j), 16'(16'hA101 + 2 * j));
          wait_gnt(1);
        end
        drive(1, 0, 0, '0, '0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    access(1, 0, 10'd107, 16'h0000, 16'hA107);

    // Port-1 address changes during port-0 WAIT; RESP sampling must use the new value.
    push(0, 0, 0, 10'd3, 16'h0000, -1);
    push(1, 0, 0, 10'd3, 16'h1003, 2);
    push(0, 1, 0, 10'd7, 16'h0000, 1);
    push(1, 1, 0, 10'd7, 16'h1007, 2);
    drive(0, 1, 0, 10'd3, '0);
    wait_gnt(0);
    drive(0, 0, 0, '0, '0);
    drive(1, 1, 0, 10'd3, 16'h5555);
    @(posedge clk); #1;
    drive(1, 1, 0, 10'd7, 16'h5555);
    wait_gnt(1);
    drive(1, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    // Reset lands in the WAIT cycle of a port-0 read: no rvalid may follow.
    push(0, 0, 0, 10'd3, 16'h0000, -1);
    drive(0, 1, 0, 10'd3, '0);
    wait_gnt(0);
    drive(0, 0, 0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midread_reset");
    repeat (3) @(posedge clk);
    #1;
    access(1, 0, 10'd2, 16'h0000, 16'h1002);

    // Top of the address range via port 1; address 0 untouched.
    access(1, 1, 10'h3FF, 16'hFFFF, 16'h0000);
    access(1, 0, 10'h3FF, 16'h0000, 16'hFFFF);
    chk("rdata1_held", 32'(rdata1), 32'h0000FFFF);
    access(1, 0, 10'h000, 16'h0000, 16'h1000);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
